read_stream_adapter: RTL and testbench

READ_STREAM_ADAPTER -- requirements
Module: read_stream_adapter

---
 rtl/read_stream_pkg.sv | 19 +
 rtl/read_stream_adapter_if.sv | 44 ++++
 rtl/read_stream_adapter.sv | 81 ++++++++
 tb/tb_read_stream_adapter.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/read_stream_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : read_stream_pkg
//  Description : Shared types and constants for the FIFO read-stream adapter.
//  Revision    : 1.0 - initial release
// ============================================================================
package read_stream_pkg;

    localparam int unsigned c_DEFAULT_DATA_WIDTH = 8;

    // Encoding doubles as the buffer occupancy reported on level.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

endpackage : read_stream_pkg
`default_nettype wire

// File: rtl/read_stream_adapter_if.sv
`default_nettype none
// ============================================================================
//  Module      : read_stream_adapter_if
//  Description : FIFO read-port and output-stream bundle for the adapter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface read_stream_adapter_if
    import read_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = c_DEFAULT_DATA_WIDTH
);

    logic                  empty;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  read_enable;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [1:0]            level;

    // Adapter side: consumes the FIFO read port, produces the stream.
    modport slave (
        input  empty,
        input  read_data,
        input  out_ready,
        output read_enable,
        output out_valid,
        output out_data,
        output level
    );

    // Environment side: FIFO storage plus downstream consumer.
    modport master (
        output empty,
        output read_data,
        output out_ready,
        input  read_enable,
        input  out_valid,
        input  out_data,
        input  level
    );

endinterface : read_stream_adapter_if
`default_nettype wire

// File: rtl/read_stream_adapter.sv
`default_nettype none
// ============================================================================
//  Module      : read_stream_adapter
//  Description : Two-entry skid buffer turning a FIFO read port into a
//                valid/ready stream at one word per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module read_stream_adapter
    import read_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = c_DEFAULT_DATA_WIDTH
) (
    input  wire logic             clock_read,
    input  wire logic             read_reset,
    input  wire logic             flush,
    read_stream_adapter_if.slave  bus
);

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] r_tail;

    logic w_pop;
    logic w_push;

    // A full buffer may still pop from the FIFO when the head leaves this cycle.
    always_comb begin
        w_pop  = (r_state != S_EMPTY) & bus.out_ready;
        w_push = ~bus.empty & ~flush & ~read_reset &
                 ((r_state != S_FULL) | w_pop);
    end

    assign bus.read_enable = w_push;
    assign bus.out_valid   = (r_state != S_EMPTY);
    assign bus.out_data    = r_head;
    assign bus.level       = r_state;

    always_ff @(posedge clock_read) begin
        if (read_reset) begin
            r_state <= S_EMPTY;
            r_head  <= '0;
            r_tail  <= '0;
        end else if (flush) begin
            r_state <= S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_push) begin
                        r_head  <= bus.read_data;
                        r_state <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (w_push && w_pop) begin
                        r_head <= bus.read_data;
                    end else if (w_push) begin
                        r_tail  <= bus.read_data;
                        r_state <= S_FULL;
                    end else if (w_pop) begin
                        r_state <= S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (w_pop) begin
                        r_head <= r_tail;
                        if (w_push) begin
                            r_tail <= bus.read_data;
                        end else begin
                            r_state <= S_ONE;
                        end
                    end
                end
                default: begin
                    r_state <= S_EMPTY;
                end
            endcase
        end
    end

endmodule : read_stream_adapter
`default_nettype wire

// File: tb/tb_read_stream_adapter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_read_stream_adapter
//  Description : Directed vector bench for read_stream_adapter with a queue
//                standing in for the FIFO storage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_read_stream_adapter;

    typedef struct {
        bit         step;
        bit         add;
        logic [7:0] word;
        bit         ready;
        bit         fl;
        bit         rst;
        bit         exp_re;
        bit         exp_v;
        bit         chk_d;
        logic [7:0] exp_d;
        logic [1:0] exp_l;
    } vec_t;

    logic clk;
    logic read_reset;
    logic flush;
    logic [7:0] q[$];
    vec_t vecs[$];
    int n_cmp = 0;
    int n_bad = 0;

    read_stream_adapter_if #(.DATA_WIDTH(8)) bus ();

    read_stream_adapter #(.DATA_WIDTH(8)) dut (
        .clock_read (clk),
        .read_reset (read_reset),
        .flush      (flush),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, check read_enable before the edge, outputs after.
    task automatic do_step(input bit ready, input bit fl, input bit rst,
                           input bit exp_re, input bit exp_v, input bit chk_d,
                           input logic [7:0] exp_d, input logic [1:0] exp_l,
                           input string tag);
        logic re;
        bit   was_empty;
        was_empty     = (q.size() == 0);
        bus.out_ready = ready;
        flush         = fl;
        read_reset    = rst;
        bus.empty     = was_empty;
        bus.read_data = was_empty ? 8'h00 : q[0];
        #1;
        re = bus.read_enable;
        chk({tag, ".read_enable"}, {31'd0, re}, {31'd0, exp_re});
        if (was_empty) chk({tag, ".re_while_empty"}, {31'd0, re}, 32'd0);
        @(posedge clk);
        #1;
        if (re === 1'b1 && q.size() > 0) void'(q.pop_front());
        chk({tag, ".out_valid"}, {31'd0, bus.out_valid}, {31'd0, exp_v});
        chk({tag, ".level"}, {30'd0, bus.level}, {30'd0, exp_l});
        if (chk_d) chk({tag, ".out_data"}, {24'd0, bus.out_data}, {24'd0, exp_d});
    endtask

    function automatic vec_t ld(input logic [7:0] w);
        vec_t v;
        v = '{step: 1'b0, add: 1'b1, word: w, ready: 1'b0, fl: 1'b0, rst: 1'b0,
              exp_re: 1'b0, exp_v: 1'b0, chk_d: 1'b0, exp_d: 8'h00, exp_l: 2'd0};
        return v;
    endfunction

    function automatic vec_t st(input bit ready, input bit rst, input bit exp_re,
                                input bit exp_v, input bit chk_d,
                                input logic [7:0] exp_d, input logic [1:0] exp_l);
        vec_t v;
        v = '{step: 1'b1, add: 1'b0, word: 8'h00, ready: ready, fl: 1'b0, rst: rst,
              exp_re: exp_re, exp_v: exp_v, chk_d: chk_d, exp_d: exp_d, exp_l: exp_l};
        return v;
    endfunction

    initial begin
        bus.out_ready = 1'b0;
        bus.empty     = 1'b1;
        bus.read_data = 8'h00;
        flush         = 1'b0;
        read_reset    = 1'b1;

        // Reset state and idle
        vecs.push_back(st(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 2'd0));
        vecs.push_back(st(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 2'd0));
        // Streaming 11,22,33 with consumer always ready
        vecs.push_back(ld(8'h11));
        vecs.push_back(ld(8'h22));
        vecs.push_back(ld(8'h33));
        vecs.push_back(st(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 2'd1));
        vecs.push_back(st(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h22, 2'd1));
        vecs.push_back(st(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h33, 2'd1));
        vecs.push_back(st(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0));
        // Backpressure with four words waiting
        vecs.push_back(ld(8'hA1));
        vecs.push_back(ld(8'hA2));
        vecs.push_back(ld(8'hA3));
        vecs.push_back(ld(8'hA4));
        vecs.push_back(st(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA1, 2'd1));
        vecs.push_back(st(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA1, 2'd2));
        vecs.push_back(st(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA1, 2'd2));
        vecs.push_back(st(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA1, 2'd2));
        // Release from full: pop and push together, then drain
        vecs.push_back(st(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA2, 2'd2));
        vecs.push_back(st(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA3, 2'd2));
        vecs.push_back(st(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA4, 2'd1));
        vecs.push_back(st(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0));

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].add) q.push_back(vecs[i].word);
            if (vecs[i].step)
                do_step(vecs[i].ready, vecs[i].fl, vecs[i].rst, vecs[i].exp_re,
                        vecs[i].exp_v, vecs[i].chk_d, vecs[i].exp_d, vecs[i].exp_l,
                        $sformatf("vec%0d", i));
        end

        // Single word at the empty boundary
        q.push_back(8'hA5);
        do_step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA5, 2'd1, "edge_a");
        do_step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, "edge_b");
        do_step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, "edge_c");

        // Flush while full, concurrent pop ignored, next word still delivered
        q.push_back(8'hB1);
        q.push_back(8'hB2);
        q.push_back(8'hB3);
        do_step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hB1, 2'd1, "flush_a");
        do_step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hB1, 2'd2, "flush_b");
        do_step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, "flush_c");
        do_step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hB3, 2'd1, "flush_d");
        do_step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, "flush_e");

        // Reset at level 1 while another word waits in the FIFO
        q.push_back(8'hC1);
        q.push_back(8'hC2);
        do_step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hC1, 2'd1, "rst_a");
        do_step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 2'd0, "rst_b");
        do_step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hC2, 2'd1, "rst_c");
        do_step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, "rst_d");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_read_stream_adapter
`default_nettype wire
